// File: rtl/regs_wb_pkg.sv
// rtl/regs_wb_pkg.sv - shared types and constants for the register-file writeback arbiter
package regs_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// rtl/regs_wb_arbiter_if.sv - ALU/load result inputs and register-file write port bundle
interface regs_wb_arbiter_if
    import regs_wb_pkg::*;
#(
    parameter int XLEN = 32
);

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  w_regs_en;
    logic [REG_ADDR_W-1:0] w_regs_addr;
    logic [XLEN-1:0]       w_regs_data;
    logic                  ld_pending;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  ld_ready, w_regs_en, w_regs_addr, w_regs_data, ld_pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output ld_ready, w_regs_en, w_regs_addr, w_regs_data, ld_pending
    );

endinterface

// File: rtl/wb_ld_fifo.sv
// rtl/wb_ld_fifo.sv - load-response buffer with per-entry kill by destination register
// Optional trace output under REGS_WB_TRACE_EN.
module wb_ld_fifo
    import regs_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_en,
    input  logic                  enq_live,
    input  logic [REG_ADDR_W-1:0] enq_rd,
    input  logic [XLEN-1:0]       enq_data,
    input  logic                  deq_en,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output logic                  head_live,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [XLEN-1:0]       head_data,
    output logic                  empty,
    output logic                  full,
    output logic                  any_live
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  live_q [DEPTH];
    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic [PTR_W-1:0]      rptr, wptr;
    logic [CNT_W-1:0]      count;

    // Kill first, then dequeue/enqueue: a fresh enqueue carries its own live bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && rd_q[i] == kill_rd) live_q[i] <= 1'b0;
            end
            if (deq_en) begin
                live_q[rptr] <= 1'b0;
                rptr         <= rptr + 1'b1;
            end
            if (enq_en) begin
                live_q[wptr] <= enq_live;
                rd_q[wptr]   <= enq_rd;
                data_q[wptr] <= enq_data;
                wptr         <= wptr + 1'b1;
            end
            count <= count + CNT_W'(enq_en) - CNT_W'(deq_en);
        end
    end

    always_comb begin
        any_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_live = any_live | live_q[i];
    end

    assign head_live = live_q[rptr];
    assign head_rd   = rd_q[rptr];
    assign head_data = data_q[rptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

`ifdef REGS_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && rd_q[i] == kill_rd) $display("WB KILL: x%0d", kill_rd);
            end
        end
    end
`endif

endmodule

// File: rtl/regs_wb_arbiter.sv
// rtl/regs_wb_arbiter.sv - merges ALU and load results onto the register-file write port
// Optional trace output under REGS_WB_TRACE_EN.
module regs_wb_arbiter
    import regs_wb_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int XLEN          = 32
) (
    input  logic               clk,
    input  logic               rst,
    regs_wb_arbiter_if.slave   bus
);

    logic                  ld_acc, kill_en, ld_live_in;
    logic                  enq_en, deq_en;
    logic                  head_live, fifo_empty, fifo_full, any_live;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_d;
    logic [XLEN-1:0]       wr_data_d;

    assign bus.ld_ready   = !fifo_full;
    assign bus.ld_pending = any_live;
    assign ld_acc         = bus.ld_valid && !fifo_full;
    assign kill_en        = bus.alu_valid && (bus.alu_rd != '0);
    // A same-cycle ALU write to the same register is younger, so the load arrives dead.
    assign ld_live_in     = (bus.ld_rd != '0) && !(kill_en && bus.ld_rd == bus.alu_rd);

    always_comb begin
        enq_en    = 1'b0;
        deq_en    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (bus.alu_valid) begin
            wr_en_d   = (bus.alu_rd != '0);
            wr_addr_d = bus.alu_rd;
            wr_data_d = bus.alu_data;
            enq_en    = ld_acc;
        end else if (!fifo_empty) begin
            deq_en    = 1'b1;
            wr_en_d   = head_live;
            wr_addr_d = head_rd;
            wr_data_d = head_data;
            enq_en    = ld_acc;
        end else if (ld_acc) begin
            wr_en_d   = (bus.ld_rd != '0);
            wr_addr_d = bus.ld_rd;
            wr_data_d = bus.ld_data;
        end
    end

    wb_ld_fifo #(
        .DEPTH (LD_FIFO_DEPTH),
        .XLEN  (XLEN)
    ) u_ld_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq_en    (enq_en),
        .enq_live  (ld_live_in),
        .enq_rd    (bus.ld_rd),
        .enq_data  (bus.ld_data),
        .deq_en    (deq_en),
        .kill_en   (kill_en),
        .kill_rd   (bus.alu_rd),
        .head_live (head_live),
        .head_rd   (head_rd),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .any_live  (any_live)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.w_regs_en   <= 1'b0;
            bus.w_regs_addr <= '0;
            bus.w_regs_data <= '0;
        end else begin
            bus.w_regs_en   <= wr_en_d;
            bus.w_regs_addr <= wr_addr_d;
            bus.w_regs_data <= wr_data_d;
        end
    end

`ifdef REGS_WB_TRACE_EN
    logic src_alu;

    always_ff @(posedge clk) begin
        if (!rst) src_alu <= 1'b0;
        else      src_alu <= bus.alu_valid;
    end

    always_ff @(posedge clk) begin
        if (rst && bus.w_regs_en)
            $display("WB WRITE: x%0d = %h (src=%s)", bus.w_regs_addr, bus.w_regs_data,
                     src_alu ? "ALU" : "LD");
        if (rst && kill_en && ld_acc && bus.ld_rd == bus.alu_rd)
            $display("WB KILL: x%0d", bus.alu_rd);
    end
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb/tb_regs_wb_arbiter.sv - directed vectors plus randomized run against a queue-based model
module tb_regs_wb_arbiter;
    import regs_wb_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regs_wb_arbiter_if #(.XLEN(32)) bus();

    regs_wb_arbiter #(
        .LD_FIFO_DEPTH (DEPTH),
        .XLEN          (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rdy;
        logic        pend;
    } vec_t;

    int        tests = 0;
    int        fails = 0;
    vec_t      tbl [20];
    wb_entry_t mq [$];

    function automatic vec_t mk(bit av, int ard, int ad, bit lv, int lrd, int ld,
                                bit en, int addr, int dat, bit rdy, bit pend);
        vec_t v;
        v.av = av;   v.ard = 5'(ard);   v.ad = 32'(ad);
        v.lv = lv;   v.lrd = 5'(lrd);   v.ld = 32'(ld);
        v.en = en;   v.addr = 5'(addr); v.data = 32'(dat);
        v.rdy = rdy; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ld;
    endtask

    // Reference: queue of pending loads; ALU always wins, then oldest load, then bypass.
    task automatic model_step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              output logic e_en, output logic [4:0] e_addr,
                              output logic [31:0] e_data, output logic e_rdy,
                              output logic e_pend, output logic acc);
        wb_entry_t e;
        acc    = lv && (mq.size() < DEPTH);
        e_en   = 1'b0;
        e_addr = '0;
        e_data = '0;
        if (av && ard != 0) begin
            foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
        end
        if (av) begin
            e_en = (ard != 0); e_addr = ard; e_data = ad;
            if (acc) begin
                e.live = (lrd != 0) && !(ard != 0 && lrd == ard);
                e.rd = lrd; e.data = ld;
                mq.push_back(e);
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            e_en = e.live; e_addr = e.rd; e_data = e.data;
            if (acc) begin
                e.live = (lrd != 0); e.rd = lrd; e.data = ld;
                mq.push_back(e);
            end
        end else if (acc) begin
            e_en = (lrd != 0); e_addr = lrd; e_data = ld;
        end
        e_rdy  = (mq.size() < DEPTH);
        e_pend = 1'b0;
        foreach (mq[i]) e_pend = e_pend | mq[i].live;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
    endtask

    initial begin
        logic        e_en, e_rdy, e_pend, acc, hold;
        logic [4:0]  e_addr, ard, lrd;
        logic [31:0] e_data, ad, ld;
        logic        av, lv;
        int          alu_pct;

        tbl[0]  = mk(1,  5, 'h1234, 0,  0, 0,       1,  5, 'h1234, 1, 0);
        tbl[1]  = mk(0,  0, 0,      0,  0, 0,       0,  0, 0,      1, 0);
        tbl[2]  = mk(0,  0, 0,      1,  7, 'hAAAA,  1,  7, 'hAAAA, 1, 0);
        tbl[3]  = mk(1,  3, 'h33,   1,  4, 'h44,    1,  3, 'h33,   1, 1);
        tbl[4]  = mk(0,  0, 0,      0,  0, 0,       1,  4, 'h44,   1, 0);
        tbl[5]  = mk(1, 11, 'hB1,   1,  8, 'h88,    1, 11, 'hB1,   1, 1);
        tbl[6]  = mk(1, 12, 'hB2,   1,  9, 'h99,    1, 12, 'hB2,   0, 1);
        tbl[7]  = mk(1, 13, 'hB3,   1, 10, 'hA0,    1, 13, 'hB3,   0, 1);
        tbl[8]  = mk(0,  0, 0,      1, 10, 'hA0,    1,  8, 'h88,   1, 1);
        tbl[9]  = mk(0,  0, 0,      1, 10, 'hA0,    1,  9, 'h99,   1, 1);
        tbl[10] = mk(0,  0, 0,      0,  0, 0,       1, 10, 'hA0,   1, 0);
        tbl[11] = mk(1, 20, 'h1,    1,  6, 'h66,    1, 20, 'h1,    1, 1);
        tbl[12] = mk(1,  6, 'h55,   0,  0, 0,       1,  6, 'h55,   1, 0);
        tbl[13] = mk(0,  0, 0,      0,  0, 0,       0,  0, 0,      1, 0);
        tbl[14] = mk(1,  0, 'h77,   0,  0, 0,       0,  0, 0,      1, 0);
        tbl[15] = mk(0,  0, 0,      1,  0, 'h78,    0,  0, 0,      1, 0);
        tbl[16] = mk(1, 14, 'hE,    1, 14, 'hF,     1, 14, 'hE,    1, 0);
        tbl[17] = mk(0,  0, 0,      0,  0, 0,       0,  0, 0,      1, 0);
        tbl[18] = mk(1,  1, 'h1,    1,  2, 'h2,     1,  1, 'h1,    1, 1);
        tbl[19] = mk(1,  3, 'h3,    1,  4, 'h4,     1,  3, 'h3,    0, 1);

        do_reset();
        chk("reset_en",   32'(bus.w_regs_en),   32'd0);
        chk("reset_addr", 32'(bus.w_regs_addr), 32'd0);
        chk("reset_data", bus.w_regs_data,      32'd0);
        chk("reset_rdy",  32'(bus.ld_ready),    32'd1);
        chk("reset_pend", 32'(bus.ld_pending),  32'd0);

        foreach (tbl[i]) begin
            set_in(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_en", i), 32'(bus.w_regs_en), 32'(tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("vec%0d_addr", i), 32'(bus.w_regs_addr), 32'(tbl[i].addr));
                chk($sformatf("vec%0d_data", i), bus.w_regs_data, tbl[i].data);
            end
            chk($sformatf("vec%0d_rdy", i),  32'(bus.ld_ready),   32'(tbl[i].rdy));
            chk($sformatf("vec%0d_pend", i), 32'(bus.ld_pending), 32'(tbl[i].pend));
        end

        // Two loads are buffered here; reset must discard them without a write.
        do_reset();
        chk("midrst_en",   32'(bus.w_regs_en),  32'd0);
        chk("midrst_rdy",  32'(bus.ld_ready),   32'd1);
        chk("midrst_pend", 32'(bus.ld_pending), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d_en", k), 32'(bus.w_regs_en), 32'd0);
        end

        do_reset();
        hold = 1'b0;
        lv = 1'b0; lrd = '0; ld = '0;
        for (int c = 0; c < 900; c++) begin
            case ((c / 60) % 3)
                0:       alu_pct = 20;
                1:       alu_pct = 60;
                default: alu_pct = 97;
            endcase
            av  = ($urandom_range(0, 99) < alu_pct);
            ard = 5'($urandom_range(0, 7));
            ad  = $urandom;
            if (!hold) begin
                lv  = ($urandom_range(0, 99) < 55);
                lrd = 5'($urandom_range(0, 7));
                ld  = $urandom;
            end
            set_in(av, ard, ad, lv, lrd, ld);
            model_step(av, ard, ad, lv, lrd, ld, e_en, e_addr, e_data, e_rdy, e_pend, acc);
            hold = lv && !acc;
            @(posedge clk);
            #1;
            chk("rnd_en", 32'(bus.w_regs_en), 32'(e_en));
            if (e_en) begin
                chk("rnd_addr", 32'(bus.w_regs_addr), 32'(e_addr));
                chk("rnd_data", bus.w_regs_data, e_data);
            end
            chk("rnd_rdy",  32'(bus.ld_ready),   32'(e_rdy));
            chk("rnd_pend", 32'(bus.ld_pending), 32'(e_pend));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regs_wb_arbiter.md
# regs_wb_arbiter

Writeback-side driver for the 32×32 register file write port (`w_regs_en`/`w_regs_addr`/`w_regs_data`). It merges two result sources onto the single write port:
- the fixed-latency ALU pipe, which cannot be stalled;
- the variable-latency load-response path, which uses a valid/ready handshake.

Load responses that lose arbitration wait in a small FIFO. A buffered load is killed if a younger ALU result targets the same register.

## Interface
Parameters:
- `LD_FIFO_DEPTH`, default 2: load buffer entries; power of two, ≥2.
- `XLEN`, default 32: data width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `alu_valid`  in  1  ALU result present this cycle; always accepted
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `ld_valid`  in  1  load response present
- `ld_ready`  out  1  block can accept a load response
- `ld_rd`  in  5  load destination register
- `ld_data`  in  XLEN  load data
- `w_regs_en`  out  1  register-file write enable (registered)
- `w_regs_addr`  out  5  register-file write address (registered)
- `w_regs_data`  out  XLEN  register-file write data (registered)
- `ld_pending`  out  1  FIFO holds at least one live entry

## Operation
- A load is accepted when `ld_valid && ld_ready`.
- `ld_ready = (count < LD_FIFO_DEPTH)`. It depends only on state, never on `ld_valid`.
- Per-cycle write priority:
  1. ALU (if `alu_valid`).
  2. FIFO head (if non-empty).
  3. Accepted load, bypassing the FIFO (only when the FIFO is empty).
- An accepted load that is not written this cycle is enqueued at the tail.
- FIFO dequeue and enqueue in the same cycle are legal; count is unchanged.
- Kill rule, applied on `alu_valid` with `alu_rd != 0`:
  - every FIFO entry with `rd == alu_rd` has its live bit cleared;
  - a load accepted in the same cycle with `ld_rd == alu_rd` is enqueued dead, or dropped if it would have bypassed.
  - The ALU result is always treated as younger than any outstanding load.
- Dead entries still occupy a slot. When a dead entry reaches the head, it is dequeued with `w_regs_en = 0`, consuming a write slot.
- x0 suppression: results with `rd == 0` from either source are accepted and consumed but produce `w_regs_en = 0`. Load entries with `rd == 0` are enqueued dead.
- `ld_pending = |live[]`.
- The FIFO uses pointer wrap-around modulo `LD_FIFO_DEPTH`, with a count register of `$clog2(DEPTH)+1` bits.

## Timing
- Reset (`rst == 0` at a `clk` edge):
  - `w_regs_en`, `w_regs_addr`, `w_regs_data` = 0;
  - count and pointers = 0, all live bits = 0;
  - therefore `ld_ready = 1` and `ld_pending = 0` the cycle after reset.
- Reset mid-operation discards all buffered loads without writing them.
- ALU latency: input at cycle N → `w_regs_en` at cycle N+1. Exactly one cycle, always.
- Load latency:
  - 1 cycle when the FIFO is empty and no ALU write occurs that cycle;
  - otherwise 1 + (ALU-occupied cycles) + (entries ahead of it).
- Full FIFO: `ld_ready = 0`. A load held by the source stays valid until accepted; `ld_data` and `ld_rd` must remain stable.
- Sustained `alu_valid`: the FIFO fills, then `ld_ready` stays low. This is legal starvation; the pipeline guarantees ALU bubbles.
- `w_regs_*` change only at `clk` edges; the register file's same-cycle forwarding consumes them directly.

## Configuration
- `REGS_WB_TRACE_EN` defined:
  - each cycle with `w_regs_en`, `$display("WB WRITE: x%0d = %h (src=%s)")` with `src` ALU or LD;
  - each kill event, `$display("WB KILL: x%0d")`.
- Undefined: no display statements. Cycle behaviour is identical either way.

## Structure
- Package `regs_wb_pkg`:
  - `REG_ADDR_W = 5`, `XLEN`;
  - `typedef struct packed {logic live; logic [4:0] rd; logic [XLEN-1:0] data;} wb_entry_t`.
- Sub-module `wb_ld_fifo`: storage, pointers, count, and a per-entry kill port (`kill_en`, `kill_rd`).
- Top level: priority mux, x0 suppression, output registers.

## Test plan
- Reset, then ALU `rd=5, data=0x1234` → next cycle `w_regs_en=1, addr=5, data=0x1234`; `ld_ready=1`.
- Load `rd=7, data=0xAAAA` with FIFO empty and no ALU → write of x7 = 0xAAAA one cycle later, `ld_pending` never asserted.
- ALU `rd=3` and load `rd=4` in the same cycle → x3 written at N+1, x4 written at N+2.
- Three loads to x8, x9, x10 during continuous ALU writes (DEPTH=2) → `ld_ready` low after two accepts; after ALU stops, x8 then x9 then x10 are written in order.
- Load `rd=6` buffered, then ALU `rd=6, data=0x55` → x6 = 0x55 written; the buffered load dequeues with `w_regs_en=0`; `ld_pending` falls.
- ALU `rd=0`, then load `rd=0` → no write enable on either; mid-test reset with 2 entries buffered → no writes after reset, `ld_ready=1`.
